// File: rtl/lagarto0_pkg.sv
// Shared core types and sizes; this slice adds what the instruction queue needs.
`default_nettype none

package lagarto0_pkg;

  localparam int ADDR_SIZE = 40;
  localparam int ISA_SIZE  = 32;
  localparam int IQ_DEPTH  = 8;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [ISA_SIZE-1:0]  inst;
  } iq_entry_t;

  // A block fetched at the upper word of an 8-byte line carries only one useful instruction.
  function automatic logic [1:0] iq_entries_for(input logic pc_bit2);
    return pc_bit2 ? 2'd1 : 2'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_block_split.sv
// Splits a 64-bit icache block into up to two {pc, inst} entries.
`default_nettype none

module iq_block_split #(
  parameter int ADDR_SIZE = lagarto0_pkg::ADDR_SIZE,
  parameter int ISA_SIZE  = lagarto0_pkg::ISA_SIZE
) (
  input  logic [2*ISA_SIZE-1:0] block_i,
  input  logic [ADDR_SIZE-1:0]  pc_i,
  output logic [1:0]            n_push_o,
  output logic [ADDR_SIZE-1:0]  pc0_o,
  output logic [ISA_SIZE-1:0]   inst0_o,
  output logic [ADDR_SIZE-1:0]  pc1_o,
  output logic [ISA_SIZE-1:0]   inst1_o
);
  import lagarto0_pkg::*;

  logic unused_pc_low;
  assign unused_pc_low = ^pc_i[1:0];

  always_comb begin
    n_push_o = iq_entries_for(pc_i[2]);
    pc1_o    = {pc_i[ADDR_SIZE-1:3], 3'b100};
    inst1_o  = block_i[2*ISA_SIZE-1:ISA_SIZE];
    if (pc_i[2]) begin
      pc0_o   = {pc_i[ADDR_SIZE-1:3], 3'b100};
      inst0_o = block_i[2*ISA_SIZE-1:ISA_SIZE];
    end else begin
      pc0_o   = {pc_i[ADDR_SIZE-1:3], 3'b000};
      inst0_o = block_i[ISA_SIZE-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
// Circular FIFO of {pc, inst} entries between the icache and decode.
`default_nettype none

module inst_queue #(
  parameter int DEPTH     = lagarto0_pkg::IQ_DEPTH,
  parameter int ADDR_SIZE = lagarto0_pkg::ADDR_SIZE,
  parameter int ISA_SIZE  = lagarto0_pkg::ISA_SIZE,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [2*ISA_SIZE-1:0] block_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  output logic                 full_o,
  input  logic                 pop_i,
  output logic                 valid_o,
  output logic [ISA_SIZE-1:0]  inst_o,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 empty_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_SIZE-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_SIZE-1:0] pc_mem_d   [DEPTH];
  logic [ISA_SIZE-1:0]  inst_mem_q [DEPTH];
  logic [ISA_SIZE-1:0]  inst_mem_d [DEPTH];

  logic [1:0]           n_push, n_acc;
  logic [ADDR_SIZE-1:0] pc0, pc1;
  logic [ISA_SIZE-1:0]  inst0, inst1;
  logic                 push_acc, pop_acc;
  logic [PTR_W-1:0]     tail_p1;

  iq_block_split #(
    .ADDR_SIZE (ADDR_SIZE),
    .ISA_SIZE  (ISA_SIZE)
  ) u_split (
    .block_i  (block_i),
    .pc_i     (pc_i),
    .n_push_o (n_push),
    .pc0_o    (pc0),
    .inst0_o  (inst0),
    .pc1_o    (pc1),
    .inst1_o  (inst1)
  );

  // Status comes only from the registered count, so no input-to-output path.
  assign full_o  = count_q > CNT_W'(DEPTH - 2);
  assign empty_o = (count_q == '0);
  assign valid_o = ~empty_o;
  assign count_o = count_q;
  assign inst_o  = inst_mem_q[head_q];
  assign pc_o    = pc_mem_q[head_q];

  assign push_acc = push_i & ~full_o & ~flush_i;
  assign pop_acc  = pop_i & valid_o & ~flush_i;
  assign n_acc    = push_acc ? n_push : 2'd0;
  assign tail_p1  = tail_q + PTR_W'(1);

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (n_acc != 2'd0) begin
        pc_mem_d[tail_q]   = pc0;
        inst_mem_d[tail_q] = inst0;
      end
      // Second word may land past the wrap point; tail_p1 wraps naturally.
      if (n_acc == 2'd2) begin
        pc_mem_d[tail_p1]   = pc1;
        inst_mem_d[tail_p1] = inst1;
      end
      tail_d  = tail_q + PTR_W'(n_acc);
      head_d  = head_q + PTR_W'(pop_acc);
      count_d = count_q + CNT_W'(n_acc) - CNT_W'(pop_acc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus queues expected entries, a monitor checks pops.
`default_nettype none

module tb_inst_queue;

  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [63:0]   block = '0;
  logic [AW-1:0] pc_in = '0;
  logic          pop = 1'b0;
  logic          full, valid, empty;
  logic [31:0]   inst;
  logic [AW-1:0] pc_out;
  logic [3:0]    count;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   inst;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  inst_queue dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .block_i (block),
    .pc_i    (pc_in),
    .full_o  (full),
    .pop_i   (pop),
    .valid_o (valid),
    .inst_o  (inst),
    .pc_o    (pc_out),
    .empty_o (empty),
    .count_o (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      check("count_bound", 64'(count <= 4'd8), 64'd1);
      if (pop && valid && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc 0x%0h expected no entry", pc_out);
        end else begin
          check("pop_pc", 64'(pc_out), 64'(exp_q[0].pc));
          check("pop_inst", 64'(inst), 64'(exp_q[0].inst));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit p, input logic [63:0] blk, input logic [AW-1:0] pc,
                      input bit pp, input bit fl);
    bit acc, pacc;
    int n;
    acc  = p && !(exp_cnt > 6) && !fl;
    pacc = pp && (exp_cnt != 0) && !fl;
    n = 0;
    if (acc) begin
      if (pc[2]) begin
        exp_q.push_back('{pc: {pc[AW-1:2], 2'b00}, inst: blk[63:32]});
        n = 1;
      end else begin
        exp_q.push_back('{pc: {pc[AW-1:3], 3'b000}, inst: blk[31:0]});
        exp_q.push_back('{pc: {pc[AW-1:3], 3'b100}, inst: blk[63:32]});
        n = 2;
      end
    end
    if (fl) exp_q.delete();
    push = p; block = blk; pc_in = pc; pop = pp; flush = fl;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0;
    exp_cnt = fl ? 0 : exp_cnt + n - (pacc ? 1 : 0);
  endtask

  function automatic logic [63:0] mkblk(input logic [AW-1:0] pc);
    return {32'hC0DE_0000 ^ 32'(pc + 4), 32'hC0DE_0000 ^ 32'(pc)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] fpc;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_pc", 64'(pc_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned block yields two entries in address order
    step(1, 64'h00000013_00100093, 40'h100, 0, 0);
    check("t1_count", 64'(count), 64'd2);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_pc", 64'(pc_out), 64'h100);
    check("t1_inst", 64'(inst), 64'h00100093);
    step(0, '0, '0, 1, 0);
    check("t1_pc2", 64'(pc_out), 64'h104);
    check("t1_inst2", 64'(inst), 64'h00000013);
    step(0, '0, '0, 1, 0);
    check("t1_empty", 64'(empty), 64'd1);

    // Upper-word fetch yields one entry
    step(1, 64'hAAAA0000_BBBB1111, 40'h10C, 0, 0);
    check("t2_count", 64'(count), 64'd1);
    check("t2_pc", 64'(pc_out), 64'h10C);
    check("t2_inst", 64'(inst), 64'hAAAA0000);
    step(0, '0, '0, 1, 0);
    check("t2_count0", 64'(count), 64'd0);

    // Fill to DEPTH, straddling the pointer wrap
    for (int i = 0; i < 4; i++) begin
      step(1, mkblk(40'h200 + 40'(8 * i)), 40'h200 + 40'(8 * i), 0, 0);
      if (i == 2) begin
        check("t3_count6", 64'(count), 64'd6);
        check("t3_full6", 64'(full), 64'd0);
      end
    end
    check("t3_count8", 64'(count), 64'd8);
    check("t3_full8", 64'(full), 64'd1);
    step(1, mkblk(40'h220), 40'h220, 0, 0);
    check("t3_ignored", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) step(0, '0, '0, 1, 0);
    check("t3_drained", 64'(count), 64'd0);

    // Steady streaming: fetch holds its PC while full
    fpc = 40'h300;
    for (int i = 0; i < 3; i++) begin
      step(1, mkblk(fpc), fpc, 0, 0);
      fpc += 8;
    end
    check("t4_count6", 64'(count), 64'd6);
    for (int i = 0; i < 20; i++) begin
      bit will_acc;
      will_acc = !(exp_cnt > 6);
      step(1, mkblk(fpc), fpc, 1, 0);
      if (will_acc) fpc += 8;
      check("t4_count", 64'(count), 64'(exp_cnt));
    end

    // Flush wins over simultaneous push and pop
    while (exp_cnt > 5) step(0, '0, '0, 1, 0);
    check("t5_count5", 64'(count), 64'd5);
    step(1, mkblk(40'h500), 40'h500, 1, 1);
    check("t5_count0", 64'(count), 64'd0);
    check("t5_empty", 64'(empty), 64'd1);
    step(1, mkblk(40'h400), 40'h400, 0, 0);
    check("t5_repush", 64'(count), 64'd2);
    check("t5_pc", 64'(pc_out), 64'h400);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);

    // Asynchronous reset mid-cycle
    step(1, mkblk(40'h600), 40'h600, 0, 0);
    step(1, mkblk(40'h608), 40'h608, 0, 0);
    check("t6_count4", 64'(count), 64'd4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(valid), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_pc", 64'(pc_out), 64'd0);
    check("t6_inst", 64'(inst), 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, '0, '0, 1, 0);
    check("t6_pop_empty", 64'(count), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
